// File: rtl/ntt_seq_pkg.sv
// Shared types and default sizing for the NTT address sequencer.
// Latency: none (types only); backpressure: not applicable.
package ntt_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_LOGN     = 12;
    localparam int DEF_PIPE_LAT = 14;

endpackage

// File: rtl/ntt_seq_delay.sv
// Valid+data shift register aligning write-back strobes with their reads.
// Latency: exactly LAT cycles; backpressure: none, shifts every cycle.
module ntt_seq_delay #(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         src_vld,
    input  logic [W-1:0] src_dat,
    output logic         dly_vld,
    output logic [W-1:0] dly_dat
);

    logic [LAT-1:0] vld_sr;
    logic [W-1:0]   dat_sr [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= src_vld;
            dat_sr[0] <= src_dat;
            for (int i = 1; i < LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                dat_sr[i] <= dat_sr[i-1];
            end
        end
    end

    assign dly_vld = vld_sr[LAT-1];
    assign dly_dat = dat_sr[LAT-1];

endmodule

// File: rtl/ntt_seq.sv
// In-place NTT address/twiddle sequencer: one butterfly issued per cycle, stage-by-stage.
// Latency: first read 1 cycle after start, write-back PIPE_LAT later; no backpressure, start ignored while running.
module ntt_seq
    import ntt_seq_pkg::*;
#(
    parameter int LOGN     = DEF_LOGN,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            inverse,
    output logic            busy,
    output logic            done,
    output logic            use_ct,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] tw_addr,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    localparam int N    = 1 << LOGN;
    localparam int HALF = N / 2;
    localparam int SW   = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int DW   = $clog2(PIPE_LAT + 1);

    localparam logic [LOGN-1:0] LAST_C = LOGN'(HALF - 1);
    localparam logic [SW-1:0]   LAST_S = SW'(LOGN - 1);
    localparam logic [DW-1:0]   LAST_D = DW'(PIPE_LAT - 1);

    typedef struct packed {
        logic [LOGN-1:0] a;
        logic [LOGN-1:0] b;
        logic [LOGN-1:0] tw;
    } bfly_t;

    // Butterfly c of stage s: half-span len is N>>(s+1) for Cooley-Tukey,
    // 1<<s for Gentleman-Sande; the twiddle base tracks the same split.
    function automatic bfly_t bfly_addr(input logic [SW-1:0] s,
                                        input logic [LOGN-1:0] c,
                                        input logic inv);
        int              lg;
        logic [LOGN-1:0] len;
        logic [LOGN-1:0] g;
        logic [LOGN-1:0] j;
        bfly_t           r;
        lg   = inv ? int'(s) : (LOGN - 1 - int'(s));
        len  = LOGN'(1) << lg;
        g    = c >> lg;
        j    = c & (len - LOGN'(1));
        r.a  = (g << (lg + 1)) | j;
        r.b  = r.a + len;
        r.tw = (inv ? (LOGN'(1) << (LOGN - 1 - int'(s))) : (LOGN'(1) << s)) + g;
        return r;
    endfunction

    state_t          state;
    logic [SW-1:0]   stage;
    logic [LOGN-1:0] cnt;
    logic [DW-1:0]   drain;
    bfly_t           rd_q;
    logic [2*LOGN-1:0] wr_pair;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            stage  <= '0;
            cnt    <= '0;
            drain  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            use_ct <= 1'b1;
            rd_en  <= 1'b0;
            rd_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= ST_ISSUE;
                        stage  <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        use_ct <= ~inverse;
                        rd_en  <= 1'b1;
                        rd_q   <= bfly_addr('0, '0, inverse);
                    end
                end
                ST_ISSUE: begin
                    if (cnt == LAST_C) begin
                        state <= ST_DRAIN;
                        drain <= '0;
                        rd_en <= 1'b0;
                    end else begin
                        cnt  <= cnt + LOGN'(1);
                        rd_q <= bfly_addr(stage, cnt + LOGN'(1), ~use_ct);
                    end
                end
                ST_DRAIN: begin
                    // Holding off until the last write-back lands keeps the
                    // next stage's reads clear of read-after-write hazards.
                    if (drain == LAST_D) begin
                        if (stage == LAST_S) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                            stage <= stage + SW'(1);
                            cnt   <= '0;
                            rd_en <= 1'b1;
                            rd_q  <= bfly_addr(stage + SW'(1), '0, ~use_ct);
                        end
                    end else begin
                        drain <= drain + DW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rd_addr_a = rd_q.a;
    assign rd_addr_b = rd_q.b;
    assign tw_addr   = rd_q.tw;

    ntt_seq_delay #(
        .W   (2 * LOGN),
        .LAT (PIPE_LAT)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .src_vld (rd_en),
        .src_dat ({rd_q.a, rd_q.b}),
        .dly_vld (wr_en),
        .dly_dat (wr_pair)
    );

    assign wr_addr_a = wr_pair[2*LOGN-1:LOGN];
    assign wr_addr_b = wr_pair[LOGN-1:0];

endmodule
